// File: rtl/con_mem_cycle_tracker_pkg.sv
// Purpose : shared types and constants for the memory-cycle tracker.
//   mem_tag_t  - per-cycle request tag {ac_ref, fetch, load_ar, load_arx}
//   ERR_*      - bit positions inside the sticky error vector
//   ptr_w()    - pointer width for a queue of a given depth (minimum 1)
package con_mem_cycle_tracker_pkg;

  typedef struct packed {
    logic ac_ref;    // cycle references fast memory (AC)
    logic fetch;     // instruction fetch cycle
    logic load_ar;   // returned word loads AR
    logic load_arx;  // returned word loads ARX
  } mem_tag_t;

  localparam int ERR_W        = 2;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_SPURIOUS = 0;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/con_mem_cycle_tracker_if.sv
// Purpose : request/completion bundle between MCL, CLK/CSH/APR and the tracker.
//   i_* signals flow into the tracker, o_* signals flow out of it.
//   slave  modport : the tracker itself
//   master modport : the environment driving requests and completions
interface con_mem_cycle_tracker_if #(
  parameter int DEPTH = 2
);
  import con_mem_cycle_tracker_pkg::*;

  localparam int CNTW = $clog2(DEPTH + 1);

  logic             i_mbox_cyc_req;
  mem_tag_t         i_req_tag;
  logic             i_mem_wait;
  logic             i_mb_xfer;
  logic             i_page_error;
  logic             i_csh_par_a;
  logic             i_csh_par_b;
  logic             i_fm_bit_36;
  logic             i_wr_even_par_data;

  logic             o_mem_cycle;
  logic             o_full;
  logic [CNTW-1:0]  o_count;
  logic             o_mbox_wait;
  logic             o_fm_xfer;
  logic             o_fetch_cycle;
  logic             o_ar_loaded;
  logic             o_arx_loaded;
  logic             o_ar_36;
  logic             o_arx_36;
  logic [ERR_W-1:0] o_err;

  modport slave (
    input  i_mbox_cyc_req, i_req_tag, i_mem_wait, i_mb_xfer, i_page_error,
           i_csh_par_a, i_csh_par_b, i_fm_bit_36, i_wr_even_par_data,
    output o_mem_cycle, o_full, o_count, o_mbox_wait, o_fm_xfer, o_fetch_cycle,
           o_ar_loaded, o_arx_loaded, o_ar_36, o_arx_36, o_err
  );

  modport master (
    output i_mbox_cyc_req, i_req_tag, i_mem_wait, i_mb_xfer, i_page_error,
           i_csh_par_a, i_csh_par_b, i_fm_bit_36, i_wr_even_par_data,
    input  o_mem_cycle, o_full, o_count, o_mbox_wait, o_fm_xfer, o_fetch_cycle,
           o_ar_loaded, o_arx_loaded, o_ar_36, o_arx_36, o_err
  );

endinterface

// File: rtl/con_mem_cycle_tracker_mem_tag_fifo.sv
// Purpose : in-order queue of request tags with flush.
//   clk, i_reset : clock, synchronous active-high reset
//   i_push/i_data: write a tag at the tail (caller never pushes into a full
//                  queue unless it pops in the same clock)
//   i_pop        : drop the head (caller never pops an empty queue)
//   i_flush      : empty the queue next clock, overrides push/pop
//   o_head       : current head tag, only meaningful while o_count != 0
//   o_count      : occupancy; o_full : occupancy == DEPTH
// Pointers wrap modulo DEPTH, so non power-of-two depths are legal.
module con_mem_cycle_tracker_mem_tag_fifo
  import con_mem_cycle_tracker_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  mem_tag_t                     i_data,
  output mem_tag_t                     o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PW   = ptr_w(DEPTH);

  mem_tag_t         r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CNTW-1:0]  r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: the storage array has no reset; r_count alone decides which slots
  // are valid, so resetting the data would only cost flops.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: reset is synchronous and sampled here, so it wins over every other
  // input in the same clock.
  always_ff @(posedge clk) begin
    if (i_reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // When full, push and pop share a slot index: the write lands in the slot
  // being vacated, and the head has already moved on by the next clock.
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNTW'(DEPTH));

endmodule

// File: rtl/con_mem_cycle_tracker.sv
// Purpose : tracks up to DEPTH outstanding MBOX / fast-memory cycles in order
//   and derives MBOX_WAIT, FM_XFER, FETCH_CYCLE, the AR/ARX loaded pulses and
//   bit-36 parity of the loaded word.
//   clk     : EBOX clock
//   i_reset : synchronous active-high master reset
//   bus     : request/completion bundle (slave side), see the interface file
module con_mem_cycle_tracker #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    i_reset,
  con_mem_cycle_tracker_if.slave  bus
);
  import con_mem_cycle_tracker_pkg::*;

  localparam int CNTW = $clog2(DEPTH + 1);

  mem_tag_t         w_head;
  logic [CNTW-1:0]  w_count;
  logic             w_full;
  logic             w_mem_cycle;
  logic             w_fm_xfer;
  logic             w_retire;
  logic             w_push;
  logic             w_overflow;
  logic             w_spurious;

  logic             r_ar_loaded;
  logic             r_arx_loaded;
  logic             r_bit36;
  logic [ERR_W-1:0] r_err;

  // Head-driven decodes look only at the head entry and occupancy, so a tag
  // enqueued this clock cannot influence them until the next clock.
  assign w_mem_cycle = (w_count != '0);
  assign w_fm_xfer   = bus.i_mem_wait & w_mem_cycle & w_head.ac_ref;
  assign w_retire    = (w_fm_xfer | bus.i_mb_xfer) & w_mem_cycle & ~bus.i_page_error;

  // A retire in the same clock frees a slot, so a full queue still accepts.
  // A page error silently swallows any request in its clock.
  assign w_push      = bus.i_mbox_cyc_req & ~bus.i_page_error & (~w_full | w_retire);
  assign w_overflow  = bus.i_mbox_cyc_req & ~bus.i_page_error & w_full & ~w_retire;
  assign w_spurious  = bus.i_mb_xfer & ~w_mem_cycle;

  con_mem_cycle_tracker_mem_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_retire),
    .i_flush (bus.i_page_error),
    .i_data  (bus.i_req_tag),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_ar_loaded  <= 1'b0;
      r_arx_loaded <= 1'b0;
      r_bit36      <= 1'b0;
      r_err        <= '0;
    end else begin
      // A cycle with neither load bit set still loads AR (legacy default).
      r_ar_loaded  <= w_retire & (w_head.load_ar | ~w_head.load_arx);
      r_arx_loaded <= w_retire & w_head.load_arx & ~w_fm_xfer;
      if (w_retire) r_bit36 <= w_fm_xfer ? bus.i_fm_bit_36
                                         : (bus.i_csh_par_a | bus.i_csh_par_b);
      if (w_overflow) r_err[ERR_OVERFLOW] <= 1'b1;
      if (w_spurious) r_err[ERR_SPURIOUS] <= 1'b1;
    end
  end

  assign bus.o_mem_cycle   = w_mem_cycle;
  assign bus.o_full        = w_full;
  assign bus.o_count       = w_count;
  assign bus.o_mbox_wait   = bus.i_mem_wait & w_mem_cycle;
  assign bus.o_fm_xfer     = w_fm_xfer;
  assign bus.o_fetch_cycle = w_mem_cycle & w_head.fetch;
  assign bus.o_ar_loaded   = r_ar_loaded;
  assign bus.o_arx_loaded  = r_arx_loaded;
  // Without a load, AR bit 36 carries the diagnostic parity-force value.
  assign bus.o_ar_36       = r_ar_loaded  ? r_bit36 : ~bus.i_wr_even_par_data;
  assign bus.o_arx_36      = r_arx_loaded ? r_bit36 : 1'b1;
  assign bus.o_err         = r_err;

endmodule

// File: tb/tb_con_mem_cycle_tracker.sv
// Bench for con_mem_cycle_tracker (DEPTH=2). Directed stimulus; every retire
// pushes its expected {ar_loaded, arx_loaded, ar_36, arx_36} into a queue that
// a monitor drains whenever a loaded pulse appears. Occupancy, flags and
// errors are compared directly after each clock.
module tb_con_mem_cycle_tracker;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] sb_q [$];

  con_mem_cycle_tracker_if #(.DEPTH(2)) bus ();

  con_mem_cycle_tracker #(.DEPTH(2)) dut (
    .clk     (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.i_mbox_cyc_req     = 1'b0;
    bus.i_req_tag          = 4'b0000;
    bus.i_mem_wait         = 1'b0;
    bus.i_mb_xfer          = 1'b0;
    bus.i_page_error       = 1'b0;
    bus.i_csh_par_a        = 1'b0;
    bus.i_csh_par_b        = 1'b0;
    bus.i_fm_bit_36        = 1'b0;
    bus.i_wr_even_par_data = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: sampled 2 time units after the edge, clear of input changes.
  always begin
    @(posedge clk);
    #2;
    if (!rst && (bus.o_ar_loaded || bus.o_arx_loaded)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pulse", 32'({bus.o_ar_loaded, bus.o_arx_loaded}), 32'(0));
      end else begin
        logic [3:0] exp_v;
        exp_v = sb_q.pop_front();
        check("sb_pulse", 32'({bus.o_ar_loaded, bus.o_arx_loaded, bus.o_ar_36, bus.o_arx_36}),
              32'(exp_v));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();

    // Reset state
    do_reset();
    check("rst_count",      32'(bus.o_count),      32'(0));
    check("rst_mem_cycle",  32'(bus.o_mem_cycle),  32'(0));
    check("rst_full",       32'(bus.o_full),       32'(0));
    check("rst_err",        32'(bus.o_err),        32'(0));
    check("rst_ar_loaded",  32'(bus.o_ar_loaded),  32'(0));
    check("rst_arx_loaded", 32'(bus.o_arx_loaded), 32'(0));
    check("rst_ar_36",      32'(bus.o_ar_36),      32'(1));
    check("rst_arx_36",     32'(bus.o_arx_36),     32'(1));

    // 1: single LOAD_AR cycle, MB_XFER two clocks after the request
    bus.i_mbox_cyc_req = 1'b1; bus.i_req_tag = 4'b0010;
    step();
    bus.i_mbox_cyc_req = 1'b0;
    check("t1_count",     32'(bus.o_count),       32'(1));
    check("t1_mem_cycle", 32'(bus.o_mem_cycle),   32'(1));
    check("t1_fetch",     32'(bus.o_fetch_cycle), 32'(0));
    step();
    check("t1_wait_count", 32'(bus.o_count), 32'(1));
    bus.i_mb_xfer = 1'b1;
    sb_q.push_back(4'b1001);
    step();
    bus.i_mb_xfer = 1'b0;
    check("t1_mem_cycle_off", 32'(bus.o_mem_cycle),  32'(0));
    check("t1_ar_loaded",     32'(bus.o_ar_loaded),  32'(1));
    check("t1_arx_loaded",    32'(bus.o_arx_loaded), 32'(0));
    step();
    check("t1_ar_pulse_end",  32'(bus.o_ar_loaded),  32'(0));

    // 2: three back-to-back requests into DEPTH=2, then in-order retire
    bus.i_mbox_cyc_req = 1'b1; bus.i_req_tag = 4'b0100;
    step();
    bus.i_req_tag = 4'b0001;
    step();
    bus.i_req_tag = 4'b0010;
    step();
    bus.i_mbox_cyc_req = 1'b0;
    check("t2_full",  32'(bus.o_full),        32'(1));
    check("t2_count", 32'(bus.o_count),       32'(2));
    check("t2_err",   32'(bus.o_err),         32'(2));
    check("t2_fetch", 32'(bus.o_fetch_cycle), 32'(1));
    bus.i_mb_xfer = 1'b1; bus.i_csh_par_a = 1'b1;
    sb_q.push_back(4'b1011);
    step();
    bus.i_mb_xfer = 1'b0; bus.i_csh_par_a = 1'b0;
    check("t2_count_1",  32'(bus.o_count),       32'(1));
    check("t2_fetch_b",  32'(bus.o_fetch_cycle), 32'(0));
    check("t2_not_full", 32'(bus.o_full),        32'(0));
    bus.i_mb_xfer = 1'b1;
    sb_q.push_back(4'b0110);
    step();
    bus.i_mb_xfer = 1'b0;
    check("t2_count_0",    32'(bus.o_count),      32'(0));
    check("t2_arx_loaded", 32'(bus.o_arx_loaded), 32'(1));
    check("t2_ar_loaded",  32'(bus.o_ar_loaded),  32'(0));
    check("t2_err_sticky", 32'(bus.o_err),        32'(2));
    step();

    // 3: fast-memory transfer of an AC_REF cycle
    do_reset();
    bus.i_mbox_cyc_req = 1'b1; bus.i_req_tag = 4'b1000;
    step();
    bus.i_mbox_cyc_req = 1'b0;
    check("t3_count", 32'(bus.o_count), 32'(1));
    bus.i_mem_wait = 1'b1; bus.i_fm_bit_36 = 1'b1;
    #1;
    check("t3_fm_xfer",   32'(bus.o_fm_xfer),   32'(1));
    check("t3_mbox_wait", 32'(bus.o_mbox_wait), 32'(1));
    sb_q.push_back(4'b1011);
    step();
    check("t3_fm_xfer_idle",   32'(bus.o_fm_xfer),    32'(0));
    check("t3_mbox_wait_idle", 32'(bus.o_mbox_wait),  32'(0));
    check("t3_count_0",        32'(bus.o_count),      32'(0));
    check("t3_ar_loaded",      32'(bus.o_ar_loaded),  32'(1));
    check("t3_ar_36",          32'(bus.o_ar_36),      32'(1));
    check("t3_arx_loaded",     32'(bus.o_arx_loaded), 32'(0));
    check("t3_err",            32'(bus.o_err),        32'(0));
    bus.i_mem_wait = 1'b0; bus.i_fm_bit_36 = 1'b0;
    step();

    // 4: page error with two outstanding plus a same-clock request and xfer
    bus.i_mbox_cyc_req = 1'b1; bus.i_req_tag = 4'b0010;
    step();
    step();
    check("t4_count_2", 32'(bus.o_count), 32'(2));
    bus.i_page_error = 1'b1; bus.i_mb_xfer = 1'b1;
    step();
    idle();
    check("t4_count_0",    32'(bus.o_count),      32'(0));
    check("t4_ar_loaded",  32'(bus.o_ar_loaded),  32'(0));
    check("t4_arx_loaded", 32'(bus.o_arx_loaded), 32'(0));
    check("t4_err",        32'(bus.o_err),        32'(0));
    step();
    check("t4_req_dropped", 32'(bus.o_count), 32'(0));

    // 5: full queue with simultaneous retire and request
    bus.i_mbox_cyc_req = 1'b1; bus.i_req_tag = 4'b0010;
    step();
    bus.i_req_tag = 4'b0001;
    step();
    bus.i_req_tag = 4'b0100; bus.i_mb_xfer = 1'b1;
    sb_q.push_back(4'b1001);
    step();
    bus.i_mbox_cyc_req = 1'b0; bus.i_mb_xfer = 1'b0;
    check("t5_count_2",   32'(bus.o_count),       32'(2));
    check("t5_full",      32'(bus.o_full),        32'(1));
    check("t5_err",       32'(bus.o_err),         32'(0));
    check("t5_fetch_arx", 32'(bus.o_fetch_cycle), 32'(0));
    bus.i_mb_xfer = 1'b1; bus.i_csh_par_b = 1'b1;
    sb_q.push_back(4'b0111);
    step();
    bus.i_csh_par_b = 1'b0;
    check("t5_count_1",     32'(bus.o_count),       32'(1));
    check("t5_fetch_new",   32'(bus.o_fetch_cycle), 32'(1));
    check("t5_arx_loaded",  32'(bus.o_arx_loaded),  32'(1));
    sb_q.push_back(4'b1001);
    step();
    check("t5_count_empty", 32'(bus.o_count), 32'(0));
    step();
    bus.i_mb_xfer = 1'b0;
    check("t5_spurious_err", 32'(bus.o_err),       32'(1));
    check("t5_spurious_nop", 32'(bus.o_ar_loaded), 32'(0));
    bus.i_mbox_cyc_req = 1'b1; bus.i_req_tag = 4'b0010;
    step();
    check("t5_pre_rst_count", 32'(bus.o_count), 32'(1));
    rst = 1'b1; bus.i_mb_xfer = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("t5_rst_count",     32'(bus.o_count),     32'(0));
    check("t5_rst_err",       32'(bus.o_err),       32'(0));
    check("t5_rst_ar_loaded", 32'(bus.o_ar_loaded), 32'(0));

    // 6: parity-force diagnostic and ARX loads
    bus.i_wr_even_par_data = 1'b1;
    #1;
    check("t6_ar_36_forced", 32'(bus.o_ar_36),  32'(0));
    check("t6_arx_36_idle",  32'(bus.o_arx_36), 32'(1));
    bus.i_mbox_cyc_req = 1'b1; bus.i_req_tag = 4'b0001;
    step();
    bus.i_mbox_cyc_req = 1'b0;
    bus.i_mb_xfer = 1'b1; bus.i_csh_par_a = 1'b1;
    sb_q.push_back(4'b0101);
    step();
    bus.i_mb_xfer = 1'b0; bus.i_csh_par_a = 1'b0;
    check("t6_arx_loaded", 32'(bus.o_arx_loaded), 32'(1));
    check("t6_arx_36",     32'(bus.o_arx_36),     32'(1));
    check("t6_ar_36",      32'(bus.o_ar_36),      32'(0));
    bus.i_mbox_cyc_req = 1'b1; bus.i_req_tag = 4'b0001;
    step();
    bus.i_mbox_cyc_req = 1'b0;
    bus.i_mb_xfer = 1'b1;
    sb_q.push_back(4'b0100);
    step();
    bus.i_mb_xfer = 1'b0;
    check("t6_arx_36_zero", 32'(bus.o_arx_36), 32'(0));
    step();
    step();
    check("sb_drain", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
